alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL expose the following ports (clock and reset first), one per line: name direction width meaning.
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  decoded-stage instruction present
- in_ready  output  1  stage can accept instruction this cycle
- instr  input  32  DLX instruction word
- rs1_data  input  32  register-file operand A
- rs2_data  input  32  register-file operand B
- flush  input  1  squash held and incoming instruction
- out_valid  output  1  registered ALU command valid
- out_ready  input  1  ALU/EX stage consumes command
- alu_d1  output  32  operand A to ALU d1
- alu_d2  output  32  operand B to ALU d2 (register or extended immediate)
- alu_func  output  6  ALU function code
- illegal  output  1  held instruction has no legal ALU mapping
- illegal_cnt  output  8  saturating count of accepted illegal instructions

Function
REQ-002 in_ready SHALL equal (!out_valid || out_ready) && !flush.
REQ-003 Accept SHALL occur when in_valid && in_ready; on accept the decoded command SHALL be registered, appearing on outputs one cycle later (latency 1).
REQ-004 When out_valid && !out_ready, all outputs SHALL hold stable.
REQ-005 out_valid SHALL set on accept, clear when out_ready is high without a new accept, and stay set on simultaneous consume+accept (back-to-back, full throughput).
REQ-006 flush SHALL clear out_valid next cycle and block any same-cycle accept; flush has priority over all other events.
REQ-007 R-type (opcode 6'h00): alu_func = instr[5:0], alu_d2 = rs2_data.
REQ-008 I-type mapping, opcode -> func: 08->100000, 09->100001, 0A->100010, 0B->100011, 0C->100100, 0D->100101, 0E->100110, 14->000100, 16->000110, 17->000111, 18->101000, 19->101001, 1A->101010, 1B->101011, 1C->101100, 1D->101101; loads 20/21/23/24/25 and stores 28/29/2B -> 100000.
REQ-009 I-type alu_d2 SHALL be instr[15:0] zero-extended for opcodes 09,0B,0C,0D,0E; sign-extended for all other I-type.
REQ-010 alu_d1 SHALL equal rs1_data for all instructions.
REQ-011 Legal R-type funcs: 000100,000110,000111,100000-100110,101000-101101 (plus 001110 per REQ-016); any other R-type func or unmapped opcode SHALL set illegal=1 with alu_func=100000, alu_d2=0.
REQ-012 illegal_cnt SHALL increment by 1 on each accepted illegal instruction and saturate at 8'hFF; flushed or unaccepted instructions SHALL NOT count.
REQ-013 illegal SHALL be registered with the command and is meaningful only while out_valid=1.

Reset
REQ-014 While rst_n=0, out_valid, illegal, illegal_cnt, alu_d1, alu_d2 SHALL be 0 and alu_func SHALL be 6'b000000, asynchronously.
REQ-015 Deassertion SHALL take effect on the next rising edge; reset mid-transfer SHALL discard the held command without counting it.

Configuration
REQ-016 Macro ALU_ISSUE_MULT_EN: defined -> R-type func 001110 is legal and passed through; undefined -> 001110 is illegal per REQ-011.

Verification
REQ-017 Reset: rst_n=0 mid-stream with out_valid=1 -> all outputs 0 immediately, illegal_cnt=0.
REQ-018 ADDI r, imm 16'hFFFF, rs1=5, out_ready=1 -> next cycle alu_func=100000, alu_d2=32'hFFFFFFFF, alu_d1=5; ANDI same imm -> alu_d2=32'h0000FFFF.
REQ-019 Backpressure: accept SUB, hold out_ready=0 3 cycles -> in_ready=0, outputs stable; raise out_ready with new in_valid -> back-to-back transfer, no bubble.
REQ-020 flush with in_valid=1 and out_valid=1 -> next cycle out_valid=0, incoming instruction dropped, illegal_cnt unchanged.
REQ-021 R-type func 001110: with ALU_ISSUE_MULT_EN -> alu_func=001110, illegal=0; without -> illegal=1, alu_func=100000, illegal_cnt+1.
REQ-022 300 accepted opcode 6'h3F instructions -> illegal_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - DLX decode-to-ALU issue register with illegal-instruction counting
// Optional feature macro: ALU_ISSUE_MULT_EN (R-type func 001110 becomes legal)
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_d1,
  output logic [31:0] alu_d2,
  output logic [5:0]  alu_func,
  output logic        illegal,
  output logic [7:0]  illegal_cnt
);

  logic [5:0]  opcode;
  logic [5:0]  rfunc;
  logic        r_legal;
  logic        i_legal;
  logic        i_zext;
  logic [5:0]  i_func;
  logic [5:0]  dec_func;
  logic [31:0] dec_d2;
  logic        dec_ill;
  logic        accept;

  assign opcode   = instr[31:26];
  assign rfunc    = instr[5:0];
  assign in_ready = (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    r_legal = 1'b0;
    case (rfunc)
      6'b000100, 6'b000110, 6'b000111,
      6'b100000, 6'b100001, 6'b100010, 6'b100011,
      6'b100100, 6'b100101, 6'b100110,
      6'b101000, 6'b101001, 6'b101010,
      6'b101011, 6'b101100, 6'b101101: r_legal = 1'b1;
`ifdef ALU_ISSUE_MULT_EN
      6'b001110:                       r_legal = 1'b1;
`endif
      default:                         r_legal = 1'b0;
    endcase
  end

  // Loads and stores issue an address add; logical immediates zero-extend.
  always_comb begin
    i_legal = 1'b1;
    i_zext  = 1'b0;
    i_func  = 6'b100000;
    case (opcode)
      6'h08: i_func = 6'b100000;
      6'h09: begin i_func = 6'b100001; i_zext = 1'b1; end
      6'h0A: i_func = 6'b100010;
      6'h0B: begin i_func = 6'b100011; i_zext = 1'b1; end
      6'h0C: begin i_func = 6'b100100; i_zext = 1'b1; end
      6'h0D: begin i_func = 6'b100101; i_zext = 1'b1; end
      6'h0E: begin i_func = 6'b100110; i_zext = 1'b1; end
      6'h14: i_func = 6'b000100;
      6'h16: i_func = 6'b000110;
      6'h17: i_func = 6'b000111;
      6'h18: i_func = 6'b101000;
      6'h19: i_func = 6'b101001;
      6'h1A: i_func = 6'b101010;
      6'h1B: i_func = 6'b101011;
      6'h1C: i_func = 6'b101100;
      6'h1D: i_func = 6'b101101;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
      6'h28, 6'h29, 6'h2B: i_func = 6'b100000;
      default: i_legal = 1'b0;
    endcase
  end

  always_comb begin
    dec_func = 6'b100000;
    dec_d2   = 32'h0;
    dec_ill  = 1'b1;
    if (opcode == 6'h00) begin
      if (r_legal) begin
        dec_func = rfunc;
        dec_d2   = rs2_data;
        dec_ill  = 1'b0;
      end
    end else if (i_legal) begin
      dec_func = i_func;
      dec_d2   = i_zext ? {16'h0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
      dec_ill  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      alu_d1      <= 32'h0;
      alu_d2      <= 32'h0;
      alu_func    <= 6'b000000;
      illegal     <= 1'b0;
      illegal_cnt <= 8'h00;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      alu_d1    <= rs1_data;
      alu_d2    <= dec_d2;
      alu_func  <= dec_func;
      illegal   <= dec_ill;
      if (dec_ill && illegal_cnt != 8'hFF)
        illegal_cnt <= illegal_cnt + 8'h01;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - randomized self-checking bench for alu_issue_stage against a table-driven reference
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = 32'h0;
  logic [31:0] rs1_data = 32'h0;
  logic [31:0] rs2_data = 32'h0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] alu_d1;
  logic [31:0] alu_d2;
  logic [5:0]  alu_func;
  logic        illegal;
  logic [7:0]  illegal_cnt;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_d1(alu_d1), .alu_d2(alu_d2),
    .alu_func(alu_func), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: one held command plus the illegal counter.
  bit        m_valid;
  bit [31:0] m_d1, m_d2;
  bit [5:0]  m_func;
  bit        m_ill;
  int        m_cnt;

  int itype_func [64];
  bit itype_zext [64];
  int pick_ops [$] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                       6'h14, 6'h16, 6'h17, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h1D,
                       6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h3F, 6'h01, 6'h2A};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_decode(input bit [31:0] ins, input bit [31:0] b,
                                     output bit [5:0] f, output bit [31:0] d2, output bit ill);
    int op, fn;
    bit ok;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    f = 6'd32; d2 = 0; ill = 1;
    if (op == 0) begin
      ok = (fn == 4 || fn == 6 || fn == 7 || (fn >= 32 && fn <= 38) || (fn >= 40 && fn <= 45));
`ifdef ALU_ISSUE_MULT_EN
      if (fn == 14) ok = 1;
`endif
      if (ok) begin f = ins[5:0]; d2 = b; ill = 0; end
    end else if (itype_func[op] >= 0) begin
      f = 6'(itype_func[op]);
      d2 = itype_zext[op] ? 32'(ins[15:0]) : 32'($signed(ins[15:0]));
      ill = 0;
    end
  endfunction

  task automatic step(input bit v, input bit [31:0] ins, input bit [31:0] a, input bit [31:0] b,
                      input bit ordy, input bit fl);
    bit acc;
    bit [5:0] f;
    bit [31:0] d2;
    bit ill;
    in_valid = v; instr = ins; rs1_data = a; rs2_data = b; out_ready = ordy; flush = fl;
    #1;
    acc = (!m_valid || ordy) && !fl;
    chk("in_ready", in_ready, acc);
    acc = acc && v;
    ref_decode(ins, b, f, d2, ill);
    @(posedge clk);
    #1;
    if (fl) m_valid = 0;
    else if (acc) begin
      m_valid = 1; m_d1 = a; m_d2 = d2; m_func = f; m_ill = ill;
      if (ill && m_cnt < 255) m_cnt++;
    end else if (ordy) m_valid = 0;
    chk("out_valid", out_valid, m_valid);
    chk("illegal_cnt", illegal_cnt, m_cnt);
    if (m_valid) begin
      chk("alu_d1", alu_d1, m_d1);
      chk("alu_d2", alu_d2, m_d2);
      chk("alu_func", alu_func, m_func);
      chk("illegal", illegal, m_ill);
    end
  endtask

  function automatic bit [31:0] rand_instr();
    bit [31:0] r;
    r = $urandom;
    r[31:26] = 6'(pick_ops[$urandom_range(pick_ops.size() - 1)]);
    return r;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_illegal"}, illegal, 0);
    chk({tag, "_cnt"}, illegal_cnt, 0);
    chk({tag, "_d1"}, alu_d1, 0);
    chk({tag, "_d2"}, alu_d2, 0);
    chk({tag, "_func"}, alu_func, 0);
  endtask

  initial begin
    int saved;
    for (int i = 0; i < 64; i++) begin itype_func[i] = -1; itype_zext[i] = 0; end
    itype_func[8'h08] = 6'b100000; itype_func[8'h09] = 6'b100001; itype_func[8'h0A] = 6'b100010;
    itype_func[8'h0B] = 6'b100011; itype_func[8'h0C] = 6'b100100; itype_func[8'h0D] = 6'b100101;
    itype_func[8'h0E] = 6'b100110; itype_func[8'h14] = 6'b000100; itype_func[8'h16] = 6'b000110;
    itype_func[8'h17] = 6'b000111; itype_func[8'h18] = 6'b101000; itype_func[8'h19] = 6'b101001;
    itype_func[8'h1A] = 6'b101010; itype_func[8'h1B] = 6'b101011; itype_func[8'h1C] = 6'b101100;
    itype_func[8'h1D] = 6'b101101;
    foreach (pick_ops[k]) if (pick_ops[k] >= 8'h20 && pick_ops[k] != 8'h3F && pick_ops[k] != 8'h2A)
      itype_func[pick_ops[k]] = 6'b100000;
    itype_zext[8'h09] = 1; itype_zext[8'h0B] = 1; itype_zext[8'h0C] = 1;
    itype_zext[8'h0D] = 1; itype_zext[8'h0E] = 1;

    m_valid = 0; m_d1 = 0; m_d2 = 0; m_func = 0; m_ill = 0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // ADDI / ANDI with imm FFFF
    step(1, {6'h08, 5'd1, 5'd2, 16'hFFFF}, 32'd5, 32'd9, 1, 0);
    chk("addi_func", alu_func, 6'b100000);
    chk("addi_d2", alu_d2, 32'hFFFFFFFF);
    chk("addi_d1", alu_d1, 32'd5);
    step(1, {6'h0C, 5'd1, 5'd2, 16'hFFFF}, 32'd5, 32'd9, 1, 0);
    chk("andi_d2", alu_d2, 32'h0000FFFF);

    // SUB held under backpressure, then back-to-back
    step(1, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100010}, 32'd100, 32'd40, 1, 0);
    repeat (3) step(1, {6'h00, 20'h0, 6'b100000}, 32'd7, 32'd8, 0, 0);
    step(1, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000}, 32'd11, 32'd22, 1, 0);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_func", alu_func, 6'b100000);

    // flush with a held command and an incoming illegal instruction
    saved = m_cnt;
    step(1, 32'hFC00_0000, 32'd1, 32'd2, 0, 1);
    chk("flush_valid", out_valid, 0);
    chk("flush_cnt", illegal_cnt, saved);

    // R-type func 001110
    step(1, {6'h00, 20'h0, 6'b001110}, 32'd3, 32'd4, 1, 0);
`ifdef ALU_ISSUE_MULT_EN
    chk("mult_func", alu_func, 6'b001110);
    chk("mult_ill", illegal, 0);
`else
    chk("mult_func", alu_func, 6'b100000);
    chk("mult_ill", illegal, 1);
    chk("mult_cnt", illegal_cnt, saved + 1);
`endif

    for (int i = 0; i < 1500; i++)
      step($urandom_range(3) != 0, rand_instr(), $urandom, $urandom,
           $urandom_range(3) != 0, $urandom_range(15) == 0);

    // mid-stream reset discards the held command
    step(1, {6'h08, 26'h1234}, 32'd6, 32'd0, 0, 0);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_valid = 0; m_cnt = 0;

    for (int i = 0; i < 300; i++)
      step(1, {6'h3F, 26'h0}, $urandom, $urandom, 1, 0);
    chk("sat_cnt", illegal_cnt, 8'hFF);

    for (int i = 0; i < 200; i++)
      step($urandom_range(1), rand_instr(), $urandom, $urandom,
           $urandom_range(1), $urandom_range(9) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
